// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment read-back path: segment codes, the
// illegal-BCD marker, segment bit positions and the frame FSM state encoding.
package seg7_pkg;

  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam logic [6:0] SEG_0     = 7'h7E;
  localparam logic [6:0] SEG_1     = 7'h30;
  localparam logic [6:0] SEG_2     = 7'h6D;
  localparam logic [6:0] SEG_3     = 7'h79;
  localparam logic [6:0] SEG_4     = 7'h33;
  localparam logic [6:0] SEG_5     = 7'h5B;
  localparam logic [6:0] SEG_6     = 7'h5F;
  localparam logic [6:0] SEG_6_ALT = 7'h1F;
  localparam logic [6:0] SEG_7     = 7'h70;
  localparam logic [6:0] SEG_7_ALT = 7'h72;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h7B;
  localparam logic [6:0] SEG_9_ALT = 7'h73;

  localparam logic [3:0] BCD_ILLEGAL = 4'hF;

  typedef enum logic [1:0] {
    SETTLE  = 2'd0,
    ARMED   = 2'd1,
    BLOCKED = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment code to BCD decoder; also reused by the
// display loop-back checker. Unknown or dark patterns report BCD_ILLEGAL.
import seg7_pkg::*;

module seg7_decode (
  input  logic [6:0] code,
  output logic [3:0] bcd,
  output logic       err
);

  // Code lookup, alternate glyphs for 6, 7 and 9 included
  always_comb begin
    bcd = BCD_ILLEGAL;
    err = 1'b1;
    case (code)
      SEG_0:                  begin bcd = 4'd0; err = 1'b0; end
      SEG_1:                  begin bcd = 4'd1; err = 1'b0; end
      SEG_2:                  begin bcd = 4'd2; err = 1'b0; end
      SEG_3:                  begin bcd = 4'd3; err = 1'b0; end
      SEG_4:                  begin bcd = 4'd4; err = 1'b0; end
      SEG_5:                  begin bcd = 4'd5; err = 1'b0; end
      SEG_6, SEG_6_ALT:       begin bcd = 4'd6; err = 1'b0; end
      SEG_7, SEG_7_ALT:       begin bcd = 4'd7; err = 1'b0; end
      SEG_8:                  begin bcd = 4'd8; err = 1'b0; end
      SEG_9, SEG_9_ALT:       begin bcd = 4'd9; err = 1'b0; end
      default:                begin bcd = BCD_ILLEGAL; err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seg7_bcd_reader.sv
// Samples a multiplexed seven-segment bus, waits for a stable one-hot frame
// and emits one ready/valid BCD record per digit whenever that digit changes.
import seg7_pkg::*;

module seg7_bcd_reader #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg,
  input  logic [DIGITS-1:0] dig_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_bcd,
  output logic [2:0]        out_idx,
  output logic              out_err
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SW = DIGITS + 7;
  localparam logic [CW-1:0]     CNT_MAX  = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
  localparam logic [DIGITS-1:0] SEL_ONE  = DIGITS'(1);
  localparam logic [DIGITS-1:0] SEL_NONE = DIGITS'(0);

  logic [SW-1:0]     s1;
  logic [SW-1:0]     s2;
  logic [CW-1:0]     cnt;
  state_t            state;
  state_t            state_nxt;
  logic [6:0]        code [DIGITS];
  logic [DIGITS-1:0] seen;
  logic [6:0]        frame_seg;
  logic [DIGITS-1:0] frame_sel;
  logic              stable;
  logic              one_hot;
  logic              accept;
  logic              due;
  logic              load;
  logic [IW-1:0]     idx;
  logic [3:0]        dec_bcd;
  logic              dec_err;

  assign frame_seg = s1[6:0];
  assign frame_sel = s1[SW-1:7];
  assign stable    = (s1 == s2);
  assign one_hot   = (frame_sel != SEL_NONE) && ((frame_sel & (frame_sel - SEL_ONE)) == SEL_NONE);
  // Accept on the cycle the counter is about to reach its limit, so ARMED
  // lines up with the counter saturating.
  assign accept    = stable && (cnt >= (CNT_MAX - CNT_ONE)) && one_hot;
  assign due       = !seen[idx] || (code[idx] != frame_seg);

  seg7_decode u_decode (
    .code (frame_seg),
    .bcd  (dec_bcd),
    .err  (dec_err)
  );

  // One-hot select to binary digit index
  always_comb begin
    idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (frame_sel[i]) begin
        idx = IW'(i);
      end else begin
        idx = idx;
      end
    end
  end

  // Input sampler and stability counter
  always_ff @(posedge clk) begin
    if (rst) begin
      s1  <= '0;
      s2  <= '0;
      cnt <= '0;
    end else begin
      s1 <= {dig_sel, seg};
      s2 <= s1;
      if (!stable) begin
        cnt <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + CNT_ONE;
      end else begin
        cnt <= cnt;
      end
    end
  end

  // Frame FSM next state and record load strobe
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    if (!stable) begin
      state_nxt = SETTLE;
    end else begin
      case (state)
        SETTLE: begin
          state_nxt = accept ? ARMED : SETTLE;
        end
        ARMED: begin
          if (!due) begin
            state_nxt = DONE;
          end else if (!out_valid) begin
            load      = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = BLOCKED;
          end
        end
        BLOCKED: begin
          if (!out_valid || out_ready) begin
            load      = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = BLOCKED;
          end
        end
        DONE: begin
          state_nxt = DONE;
        end
        default: begin
          state_nxt = SETTLE;
        end
      endcase
    end
  end

  // FSM state, per-digit code store and single-entry output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= SETTLE;
      seen      <= '0;
      out_valid <= 1'b0;
      out_bcd   <= 4'h0;
      out_idx   <= 3'd0;
      out_err   <= 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        code[i] <= 7'h00;
      end
    end else begin
      state <= state_nxt;
      if (load) begin
        code[idx] <= frame_seg;
        seen[idx] <= 1'b1;
        out_valid <= 1'b1;
        out_bcd   <= dec_bcd;
        out_idx   <= 3'(idx);
        out_err   <= dec_err;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= out_valid;
      end
    end
  end

endmodule

// File: tb/tb_seg7_bcd_reader.sv
// Self-checking bench for seg7_bcd_reader: decode table, latency, change
// filter, glitch rejection, back-pressure and reset-during-handshake.
module tb_seg7_bcd_reader;

  typedef struct packed {
    logic [3:0] bcd;
    logic [2:0] idx;
    logic       err;
  } rec_t;

  typedef struct {
    int         digit;
    logic [6:0] seg;
    logic [3:0] bcd;
    logic       err;
    logic       due;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [6:0] seg;
  logic [3:0] dig_sel;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_bcd;
  logic [2:0] out_idx;
  logic       out_err;

  int   checks;
  int   errors;
  int   rec_count;
  rec_t exp_q[$];
  vec_t vecs[18];

  seg7_bcd_reader #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .seg       (seg),
    .dig_sel   (dig_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bcd   (out_bcd),
    .out_idx   (out_idx),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int digit, input logic [6:0] code);
    dig_sel = 4'b0001 << digit;
    seg     = code;
  endtask

  task automatic expect_rec(input logic [3:0] bcd, input int digit, input logic err);
    rec_t r;
    r.bcd = bcd;
    r.idx = 3'(digit);
    r.err = err;
    exp_q.push_back(r);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    dig_sel   = 4'b0000;
    seg       = 7'h00;
    out_ready = 1'b1;
    step(3);
    rst = 1'b0;
    step(1);
  endtask

  // Scoreboard: pop and compare on each handshake, check hold under back-pressure
  initial begin
    logic [15:0] held;
    logic        hold_prev;
    rec_t        r;
    hold_prev = 1'b0;
    held      = 16'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          chk("hold_stable", {8'h0, out_valid, out_bcd, out_idx}, held);
        end
        if (out_valid && out_ready) begin
          rec_count++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_record: got bcd=%0h idx=%0d err=%0b expected none at %0t",
                     out_bcd, out_idx, out_err, $time);
          end else begin
            r = exp_q.pop_front();
            chk("record", {8'h0, out_bcd, out_idx, out_err}, {8'h0, r});
          end
        end
        hold_prev = out_valid && !out_ready;
        held      = {8'h0, out_valid, out_bcd, out_idx};
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    checks    = 0;
    errors    = 0;
    rec_count = 0;

    vecs[0]  = '{3, 7'h7E, 4'd0, 1'b0, 1'b1};
    vecs[1]  = '{3, 7'h30, 4'd1, 1'b0, 1'b1};
    vecs[2]  = '{3, 7'h6D, 4'd2, 1'b0, 1'b1};
    vecs[3]  = '{3, 7'h79, 4'd3, 1'b0, 1'b1};
    vecs[4]  = '{3, 7'h33, 4'd4, 1'b0, 1'b1};
    vecs[5]  = '{3, 7'h5B, 4'd5, 1'b0, 1'b1};
    vecs[6]  = '{3, 7'h5F, 4'd6, 1'b0, 1'b1};
    vecs[7]  = '{3, 7'h1F, 4'd6, 1'b0, 1'b1};
    vecs[8]  = '{3, 7'h70, 4'd7, 1'b0, 1'b1};
    vecs[9]  = '{3, 7'h72, 4'd7, 1'b0, 1'b1};
    vecs[10] = '{3, 7'h7F, 4'd8, 1'b0, 1'b1};
    vecs[11] = '{3, 7'h7B, 4'd9, 1'b0, 1'b1};
    vecs[12] = '{3, 7'h73, 4'd9, 1'b0, 1'b1};
    vecs[13] = '{3, 7'h00, 4'hF, 1'b1, 1'b1};
    vecs[14] = '{2, 7'h49, 4'hF, 1'b1, 1'b1};
    vecs[15] = '{3, 7'h00, 4'hF, 1'b1, 1'b0};
    vecs[16] = '{2, 7'h49, 4'hF, 1'b1, 1'b0};
    vecs[17] = '{2, 7'h7E, 4'd0, 1'b0, 1'b1};

    rst       = 1'b1;
    dig_sel   = 4'b0000;
    seg       = 7'h00;
    out_ready = 1'b1;
    step(1);
    chk("reset_valid", {15'h0, out_valid}, 16'h0);
    chk("reset_outs", {8'h0, out_bcd, out_idx, out_err}, 16'h0);
    do_reset();

    // First record latency: valid rises on the 6th edge after the pins are sampled
    drive(0, 7'h30);
    expect_rec(4'd1, 0, 1'b0);
    for (int k = 0; k <= 6; k++) begin
      step(1);
      if (k == 5) chk("latency_early", {15'h0, out_valid}, 16'h0);
      if (k == 6) chk("latency_valid", {15'h0, out_valid}, 16'h1);
    end
    step(6);
    chk("latency_drain", 16'(exp_q.size()), 16'h0);

    // Decode table with change filter
    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].digit, vecs[i].seg);
      if (vecs[i].due) expect_rec(vecs[i].bcd, vecs[i].digit, vecs[i].err);
      step(10);
    end
    chk("table_drain", 16'(exp_q.size()), 16'h0);

    // Scan 2,0,2,4 twice: records only on the first pass
    do_reset();
    n0 = rec_count;
    for (int pass = 0; pass < 2; pass++) begin
      for (int d = 0; d < 4; d++) begin
        logic [6:0] scan_codes [4];
        logic [3:0] scan_bcd [4];
        scan_codes = '{7'h6D, 7'h7E, 7'h6D, 7'h33};
        scan_bcd   = '{4'd2, 4'd0, 4'd2, 4'd4};
        drive(d, scan_codes[d]);
        if (pass == 0) expect_rec(scan_bcd[d], d, 1'b0);
        step(10);
      end
      chk("scan_pass_records", 16'(rec_count - n0), 16'd4);
    end
    chk("scan_drain", 16'(exp_q.size()), 16'h0);

    // Glitches and non-one-hot selects never produce records
    do_reset();
    n0 = rec_count;
    for (int g = 0; g < 10; g++) begin
      drive(0, g[0] ? 7'h30 : 7'h7E);
      step(2);
    end
    dig_sel = 4'b0011;
    seg     = 7'h7E;
    step(12);
    dig_sel = 4'b0000;
    step(12);
    chk("glitch_no_record", 16'(rec_count - n0), 16'h0);

    // Back-pressure: digit 0 held pending, digit 1 blocked, then back-to-back
    do_reset();
    out_ready = 1'b0;
    drive(0, 7'h33);
    expect_rec(4'd4, 0, 1'b0);
    step(10);
    drive(1, 7'h5B);
    expect_rec(4'd5, 1, 1'b0);
    step(20);
    chk("bp_pending", {8'h0, out_valid, out_bcd, out_idx}, {8'h0, 1'b1, 4'd4, 3'd0});
    out_ready = 1'b1;
    step(1);
    chk("bp_back_to_back", {8'h0, out_valid, out_bcd, out_idx}, {8'h0, 1'b1, 4'd5, 3'd1});
    step(1);
    chk("bp_cleared", {15'h0, out_valid}, 16'h0);
    step(10);
    chk("bp_drain", 16'(exp_q.size()), 16'h0);

    // Reset while a record is pending drops it; the pattern is re-emitted afterwards
    do_reset();
    out_ready = 1'b0;
    drive(0, 7'h30);
    expect_rec(4'd1, 0, 1'b0);
    step(10);
    chk("rst_pending", {15'h0, out_valid}, 16'h1);
    rst = 1'b1;
    step(1);
    chk("rst_drops_valid", {15'h0, out_valid}, 16'h0);
    rst       = 1'b0;
    out_ready = 1'b1;
    step(10);
    chk("rst_reemit_drain", 16'(exp_q.size()), 16'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
